// File: rtl/multiplicador_seq_param_if.sv
`default_nettype none
// ============================================================================
// Module   : multiplicador_seq_param_if
// Brief    : Start/operand/result handshake bundle for the sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface multiplicador_seq_param_if #(
    parameter int N = 4
);
    logic           St;
    logic           Sinal;
    logic [N-1:0]   Multiplicando;
    logic [N-1:0]   Multiplicador;
    logic [2*N-1:0] Produto;
    logic           Idle;
    logic           Done;

    modport master (
        output St, Sinal, Multiplicando, Multiplicador,
        input  Produto, Idle, Done
    );

    modport slave (
        input  St, Sinal, Multiplicando, Multiplicador,
        output Produto, Idle, Done
    );
endinterface
`default_nettype wire

// File: rtl/multiplicador_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : multiplicador_seq_param
// Brief    : N-bit shift-add multiplier, one partial product per clock,
//            unsigned or two's-complement selected at start.
// Revision : 1.0 - initial release
// ============================================================================
module multiplicador_seq_param #(
    parameter int N = 4
) (
    input  wire logic                    Clk,
    input  wire logic                    Reset,
    multiplicador_seq_param_if.slave     bus
);
    localparam int c_CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [N-1:0]       r_m_q,     w_m_d;
    logic [N-1:0]       r_q_q,     w_q_d;
    logic               r_s_q,     w_s_d;
    logic [N:0]         r_acc_q,   w_acc_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [2*N-1:0]     r_prod_q,  w_prod_d;

    logic [N:0]         w_ext;
    logic [N:0]         w_sum;
    logic [N:0]         w_acc_sh;
    logic [N-1:0]       w_q_sh;
    logic               w_last;
    logic               w_fill;

    always_comb begin
        w_state_d = r_state_q;
        w_m_d     = r_m_q;
        w_q_d     = r_q_q;
        w_s_d     = r_s_q;
        w_acc_d   = r_acc_q;
        w_cnt_d   = r_cnt_q;
        w_prod_d  = r_prod_q;

        w_ext  = r_s_q ? {r_m_q[N-1], r_m_q} : {1'b0, r_m_q};
        w_last = (r_cnt_q == c_CNT_W'(N - 1));

        // The multiplier MSB carries weight -2^(N-1) in signed mode, so the
        // final partial product is subtracted instead of added.
        if (r_q_q[0]) begin
            w_sum = (w_last && r_s_q) ? (r_acc_q - w_ext) : (r_acc_q + w_ext);
        end else begin
            w_sum = r_acc_q;
        end

        // Unsigned partial sums always fit in N+1 bits, so the refill is zero.
        w_fill   = r_s_q ? w_sum[N] : 1'b0;
        w_acc_sh = {w_fill, w_sum[N:1]};
        w_q_sh   = {w_sum[0], r_q_q[N-1:1]};

        case (r_state_q)
            ST_IDLE: begin
                if (bus.St) begin
                    w_m_d     = bus.Multiplicando;
                    w_q_d     = bus.Multiplicador;
                    w_s_d     = bus.Sinal;
                    w_acc_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                w_acc_d = w_acc_sh;
                w_q_d   = w_q_sh;
                w_cnt_d = r_cnt_q + c_CNT_W'(1);
                if (w_last) begin
                    w_prod_d  = {w_acc_sh[N-1:0], w_q_sh};
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_q <= ST_IDLE;
            r_m_q     <= '0;
            r_q_q     <= '0;
            r_s_q     <= 1'b0;
            r_acc_q   <= '0;
            r_cnt_q   <= '0;
            r_prod_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_m_q     <= w_m_d;
            r_q_q     <= w_q_d;
            r_s_q     <= w_s_d;
            r_acc_q   <= w_acc_d;
            r_cnt_q   <= w_cnt_d;
            r_prod_q  <= w_prod_d;
        end
    end

    assign bus.Idle    = (r_state_q == ST_IDLE);
    assign bus.Done    = (r_state_q == ST_DONE);
    assign bus.Produto = r_prod_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplicador_seq_param
// Brief    : Self-checking bench for the sequential multiplier at N=4 and N=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplicador_seq_param;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    multiplicador_seq_param_if #(.N(4)) if4 ();
    multiplicador_seq_param_if #(.N(8)) if8 ();

    multiplicador_seq_param #(.N(4)) u_dut4 (.Clk(Clk), .Reset(Reset), .bus(if4));
    multiplicador_seq_param #(.N(8)) u_dut8 (.Clk(Clk), .Reset(Reset), .bus(if8));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [15:0] ref_mul(input int n, input logic [7:0] a,
                                            input logic [7:0] b, input bit s);
        longint x, y, p, msk;
        msk = (longint'(1) << n) - 1;
        x = longint'(a) & msk;
        y = longint'(b) & msk;
        if (s && x >= (longint'(1) << (n - 1))) x -= (longint'(1) << n);
        if (s && y >= (longint'(1) << (n - 1))) y -= (longint'(1) << n);
        p = x * y;
        return 16'(p & ((longint'(1) << (2 * n)) - 1));
    endfunction

    // Timing model: a start is accepted when ready, the result appears n
    // edges later and the unit is ready again one edge after that.
    int          m_busy  [2];
    int          m_left  [2];
    bit          m_done  [2];
    logic [15:0] m_prod  [2];
    logic [15:0] m_pend  [2];
    bit          m_valid = 1'b0;

    task automatic model_step(input int k, input int n, input logic st,
                              input logic [7:0] a, input logic [7:0] b, input logic s);
        if (Reset) begin
            m_busy[k] = 0; m_left[k] = 0; m_done[k] = 1'b0; m_prod[k] = '0;
        end else if (m_done[k]) begin
            m_done[k] = 1'b0; m_busy[k] = 0;
        end else if (m_busy[k] != 0) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
                m_done[k] = 1'b1; m_prod[k] = m_pend[k];
            end
        end else if (st) begin
            m_busy[k] = 1; m_left[k] = n; m_pend[k] = ref_mul(n, a, b, s);
        end
    endtask

    always @(posedge Clk) begin
        model_step(0, 4, if4.St, {4'b0, if4.Multiplicando}, {4'b0, if4.Multiplicador}, if4.Sinal);
        model_step(1, 8, if8.St, if8.Multiplicando, if8.Multiplicador, if8.Sinal);
        if (Reset) m_valid = 1'b1;
        #2;
        if (m_valid) begin
            chk("idle4", 16'(if4.Idle), 16'(m_busy[0] == 0 && !m_done[0]));
            chk("done4", 16'(if4.Done), 16'(m_done[0]));
            chk("prod4", 16'(if4.Produto), m_prod[0]);
            chk("idle8", 16'(if8.Idle), 16'(m_busy[1] == 0 && !m_done[1]));
            chk("done8", 16'(if8.Done), 16'(m_done[1]));
            chk("prod8", if8.Produto, m_prod[1]);
        end
    end

    function automatic logic get_done(input int k);
        return (k == 0) ? if4.Done : if8.Done;
    endfunction
    function automatic logic get_idle(input int k);
        return (k == 0) ? if4.Idle : if8.Idle;
    endfunction
    function automatic logic [15:0] get_prod(input int k);
        return (k == 0) ? 16'(if4.Produto) : if8.Produto;
    endfunction

    task automatic drive(input int k, input logic st, input logic [7:0] a,
                         input logic [7:0] b, input logic s);
        if (k == 0) begin
            if4.St = st; if4.Multiplicando = a[3:0]; if4.Multiplicador = b[3:0]; if4.Sinal = s;
        end else begin
            if8.St = st; if8.Multiplicando = a; if8.Multiplicador = b; if8.Sinal = s;
        end
    endtask

    task automatic op(input int k, input logic [7:0] a, input logic [7:0] b, input bit s,
                      input bit use_lit, input logic [15:0] lit, input string name);
        int j;
        int n;
        n = (k == 0) ? 4 : 8;
        @(negedge Clk);
        drive(k, 1'b1, a, b, s);
        @(negedge Clk);
        drive(k, 1'b0, $urandom, $urandom, 1'($urandom));
        j = 0;
        while (!get_done(k) && j < 40) begin
            @(negedge Clk);
            j++;
        end
        chk({name, "_latency"}, 16'(j), 16'(n));
        if (use_lit) chk(name, get_prod(k), lit);
        @(negedge Clk);
    endtask

    logic [7:0] b2b_a [4];
    logic [7:0] b2b_b [4];
    logic       b2b_s [4];

    task automatic b2b(input int k);
        int idx, last, cyc, ndone, n;
        n = (k == 0) ? 4 : 8;
        idx = 1; last = -1; cyc = 0; ndone = 0;
        @(negedge Clk);
        drive(k, 1'b1, b2b_a[0], b2b_b[0], b2b_s[0]);
        while (ndone < 4 && cyc < 200) begin
            @(negedge Clk);
            cyc++;
            if (get_done(k)) begin
                if (last >= 0) chk("b2b_period", 16'(cyc - last), 16'(n + 2));
                last = cyc;
                ndone++;
                if (idx < 4) begin
                    drive(k, 1'b1, b2b_a[idx], b2b_b[idx], b2b_s[idx]);
                    idx++;
                end else begin
                    drive(k, 1'b0, 8'h00, 8'h00, 1'b0);
                end
            end else if (!get_idle(k)) begin
                drive(k, 1'b1, $urandom, $urandom, 1'($urandom));
            end
        end
        chk("b2b_count", 16'(ndone), 16'd4);
        @(negedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int j;
        // Reset held with a pending start and random operands.
        Reset = 1'b1;
        drive(0, 1'b1, $urandom, $urandom, 1'($urandom));
        drive(1, 1'b1, $urandom, $urandom, 1'($urandom));
        repeat (2) @(negedge Clk);
        chk("rst_idle4", 16'(if4.Idle), 16'd1);
        chk("rst_done4", 16'(if4.Done), 16'd0);
        chk("rst_prod4", 16'(if4.Produto), 16'h0000);
        chk("rst_prod8", if8.Produto, 16'h0000);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        Reset = 1'b0;

        op(0, 8'd15, 8'd15, 1'b0, 1'b1, 16'h00E1, "u15x15");
        op(0, 8'd0,  8'd15, 1'b0, 1'b1, 16'h0000, "u0x15");
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op(0, 8'(a), 8'(b), 1'b0, 1'b0, 16'h0000, "exh");

        op(0, 8'h08, 8'h08, 1'b1, 1'b1, 16'h0040, "s_m8xm8");
        op(0, 8'h08, 8'h07, 1'b1, 1'b1, 16'h00C8, "s_m8x7");
        op(0, 8'h0F, 8'h0F, 1'b1, 1'b1, 16'h0001, "s_m1xm1");
        op(0, 8'h07, 8'h0F, 1'b1, 1'b1, 16'h00F9, "s_7xm1");
        op(0, 8'h00, 8'h08, 1'b1, 1'b1, 16'h0000, "s_0xm8");

        b2b_a = '{8'h03, 8'h08, 8'h0F, 8'h07};
        b2b_b = '{8'h05, 8'h08, 8'h0F, 8'h0F};
        b2b_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        b2b(0);

        // Abort 3*5 at its third iteration; no result and no Done may follow.
        @(negedge Clk);
        drive(0, 1'b1, 8'd3, 8'd5, 1'b0);
        @(negedge Clk);
        drive(0, 1'b0, 8'd3, 8'd5, 1'b0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_idle", 16'(if4.Idle), 16'd1);
        chk("abort_done", 16'(if4.Done), 16'd0);
        chk("abort_prod", 16'(if4.Produto), 16'h0000);
        for (j = 0; j < 8; j++) begin
            @(negedge Clk);
            chk("abort_nodone", 16'(if4.Done), 16'd0);
        end
        op(0, 8'd3, 8'd5, 1'b0, 1'b1, 16'h000F, "u3x5_after_abort");

        op(1, 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01, "n8_u255x255");
        op(1, 8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, "n8_s_m128xm128");
        op(1, 8'h7F, 8'h80, 1'b1, 1'b1, 16'hC080, "n8_s_127xm128");

        b2b_a = '{8'hFF, 8'h80, 8'h7F, 8'h12};
        b2b_b = '{8'hFF, 8'h80, 8'h80, 8'h34};
        b2b_s = '{1'b0, 1'b1, 1'b1, 1'b0};
        b2b(1);

        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
